// File: rtl/status_indicator.sv
// N-channel LED indicator driver: each channel shows its status input as a level,
// a stretched pulse, a gated blink or the shared heartbeat, selected at run time.
module status_indicator #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CLK_HZ     = 200000000,
  parameter int unsigned BLINK_HZ   = 1,
  parameter int unsigned STRETCH_MS = 50
) (
  input  logic              sysclk,
  input  logic              sysrst,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   sig,
  output logic [N_CH-1:0]   leds,
  output logic              hb
);

  localparam int unsigned P  = CLK_HZ / 1000;
  localparam int unsigned H  = 500 / BLINK_HZ;
  localparam int unsigned SW = $clog2(STRETCH_MS + 1);
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned HW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    MODE_LEVEL     = 2'b00,
    MODE_STRETCH   = 2'b01,
    MODE_BLINK     = 2'b10,
    MODE_HEARTBEAT = 2'b11
  } mode_e;

  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            hb_q, hb_d;
  logic [N_CH-1:0] sig_dly_q, sig_dly_d;
  logic [N_CH-1:0] leds_q, leds_d;
  logic [SW-1:0]   scnt_q [N_CH];
  logic [SW-1:0]   scnt_d [N_CH];
  logic            ms_tick;
  logic [N_CH-1:0] ch_edge;

  assign ms_tick = (pcnt_q == PW'(P - 1));

  always_comb begin
    pcnt_d    = ms_tick ? '0 : pcnt_q + PW'(1);
    hcnt_d    = hcnt_q;
    hb_d      = hb_q;
    sig_dly_d = sig;
    leds_d    = '0;
    ch_edge   = sig & ~sig_dly_q;

    if (ms_tick) begin
      if (hcnt_q == HW'(H - 1)) begin
        hcnt_d = '0;
        hb_d   = ~hb_q;
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end

    for (int unsigned i = 0; i < N_CH; i++) begin
      // A fresh edge reloads even when a tick lands in the same cycle.
      scnt_d[i] = scnt_q[i];
      if (ch_edge[i]) begin
        scnt_d[i] = SW'(STRETCH_MS);
      end else if (ms_tick && (scnt_q[i] != '0)) begin
        scnt_d[i] = scnt_q[i] - SW'(1);
      end

      // Stretch shows the count from before this cycle's update, hence its 2-cycle latency.
      case (mode_e'(mode[2*i +: 2]))
        MODE_LEVEL:     leds_d[i] = sig[i];
        MODE_STRETCH:   leds_d[i] = (scnt_q[i] != '0);
        MODE_BLINK:     leds_d[i] = sig[i] & hb_q;
        MODE_HEARTBEAT: leds_d[i] = hb_q;
        default:        leds_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (sysrst) begin
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      hb_q      <= 1'b0;
      sig_dly_q <= '0;
      leds_q    <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        scnt_q[i] <= '0;
      end
    end else begin
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      hb_q      <= hb_d;
      sig_dly_q <= sig_dly_d;
      leds_q    <= leds_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        scnt_q[i] <= scnt_d[i];
      end
    end
  end

  assign leds = leds_q;
  assign hb   = hb_q;

endmodule
